pngen_burst_ctrl: RTL and testbench
===================================

PNGEN_BURST_CTRL -- requirements
Module: pngen_burst_ctrl

Interface
REQ-001 The block SHALL provide parameter LEN_W, default 16, giving the burst and gap length width.
REQ-002 The block SHALL provide parameter CNT_W, default 8, giving the burst count width.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 pnClkEn  input  1  one-cycle bit strobe from the PN phase accumulator.
REQ-006 start  input  1  one-cycle request to begin a burst sequence.
REQ-007 abort  input  1  one-cycle request to stop immediately.
REQ-008 burstLen  input  LEN_W  bits per burst; 0 is treated as 1.
REQ-009 gapLen  input  LEN_W  idle bit times between bursts; 0 means no gap.
REQ-010 burstCount  input  CNT_W  bursts per sequence; 0 means continuous.
REQ-011 restartEach  input  1  1 = restart the LFSR before every burst; 0 = restart before the first burst only.
REQ-012 pnRestart  output  1  one-cycle LFSR reload pulse.
REQ-013 pnGate  output  1  high while in BURST; ANDed with the LFSR enable.
REQ-014 bitValid  output  1  pnClkEn qualified by BURST; marks each transmitted bit.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on normal sequence completion.
REQ-017 burstIdx  output  CNT_W  zero-based index of the current burst.

Function
REQ-018 The block SHALL implement states IDLE, PRELOAD, BURST, GAP and DONE.
REQ-019 IDLE: on start with abort low, the block SHALL latch burstLen, gapLen, burstCount and restartEach, clear burstIdx, and go to PRELOAD on the next cycle.
REQ-020 PRELOAD SHALL last exactly one cycle, assert pnRestart registered in that cycle, then enter BURST.
REQ-021 In BURST, each pnClkEn SHALL increment bitCnt; the strobe arriving with bitCnt == latched burstLen-1 is the final bit of the burst.
REQ-022 On the final burst bit, the block SHALL clear bitCnt and apply the first matching rule: last burst -> DONE; gapLen != 0 -> GAP; restartEach = 1 -> PRELOAD; otherwise stay in BURST with burstIdx incremented.
REQ-023 "Last burst" SHALL mean burstCount != 0 and burstIdx == burstCount-1; when burstCount == 0 no burst is last.
REQ-024 GAP SHALL count gapLen pnClkEn strobes, then increment burstIdx and go to PRELOAD if restartEach = 1, else to BURST.
REQ-025 DONE SHALL last one cycle with done = 1, then return to IDLE.
REQ-026 bitValid SHALL be combinational: pnClkEn AND (state == BURST); every other output SHALL be registered.
REQ-027 Latency from start to first possible bitValid SHALL be 2 cycles (IDLE -> PRELOAD -> BURST).
REQ-028 abort SHALL force IDLE on the next edge from any state; done SHALL not pulse, and counters SHALL clear.
REQ-029 If start and abort are high in the same cycle, abort SHALL win.
REQ-030 start while busy SHALL be ignored.
REQ-031 Config inputs changing while busy SHALL have no effect until the next start.
REQ-032 In continuous mode, burstIdx SHALL wrap from all-ones to 0.
REQ-033 pnClkEn during PRELOAD or DONE SHALL be ignored and not counted.
REQ-034 The block SHALL produce exactly max(burstLen,1) bitValid pulses per burst.

Reset
REQ-035 While reset is low, the block SHALL be in IDLE and all outputs and counters SHALL be 0.
REQ-036 Reset asserted mid-sequence SHALL discard all latched config and counters, with no done pulse.

Structure
REQ-037 Package pngen_burst_pkg SHALL hold the state enumeration, default LEN_W and CNT_W, and state encodings.
REQ-038 One sub-module, pngen_strobe_cnt, SHALL be used as a terminal-count strobe counter (load, count on strobe, terminal flag), instantiated for the bit/gap counter and the burst counter.

Verification
REQ-039 burstLen=4, gapLen=2, burstCount=3, restartEach=0, pnClkEn every 3rd cycle, start -> pnRestart once; 12 bitValid pulses in groups of 4 separated by 2 gap strobes; burstIdx 0,1,2; one done pulse; busy falls the cycle after done.
REQ-040 Same stimulus with restartEach=1 -> 3 pnRestart pulses, each exactly one cycle before the BURST entry it precedes.
REQ-041 burstLen=0, gapLen=0, burstCount=2, pnClkEn every cycle -> 2 bitValid pulses, then done.
REQ-042 burstCount=0, burstLen=1, gapLen=0, restartEach=0, CNT_W=8, 300 strobes -> burstIdx wraps 255->0; no done; abort -> IDLE next cycle with all outputs 0.
REQ-043 start and abort in the same cycle -> stays IDLE; start during BURST -> ignored; reset low mid-GAP -> all outputs 0 immediately, asynchronously.
REQ-044 Change burstLen from 4 to 9 mid-sequence -> bursts remain 4 bits; the next start uses 9.

Source files
------------

// File: rtl/pngen_burst_pkg.sv
// Shared definitions for the PN burst controller.
//   LEN_W_DEF / CNT_W_DEF : default burst/gap length width and burst count width
//   state_e               : controller state encoding
package pngen_burst_pkg;

    localparam int unsigned LEN_W_DEF = 16;
    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned STATE_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_PRELOAD = 3'd1,
        ST_BURST   = 3'd2,
        ST_GAP     = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/pngen_strobe_cnt.sv
// Terminal-count strobe counter.
//   clk, rst_n : clock, async active-low reset
//   ld_i       : load ld_val_i (has priority over inc_i)
//   inc_i      : count strobe, increments with natural wrap
//   term_i     : terminal value compared against the count
//   cnt_o      : registered count
//   term_c     : combinational flag, count == term_i
module pngen_strobe_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    input  logic         inc_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] cnt_o,
    output logic         term_c
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (ld_i) begin
            cnt_q <= ld_val_i;
        end else if (inc_i) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign term_c = (cnt_q == term_i);

endmodule

// File: rtl/pngen_burst_ctrl.sv
// PN generator burst controller: sequences LFSR reload, burst gating and
// inter-burst gaps, counted in pnClkEn bit strobes.
//   clk, reset   : clock, async active-low reset
//   pnClkEn      : bit strobe from the PN phase accumulator
//   start, abort : sequence start / immediate stop requests
//   burstLen, gapLen, burstCount, restartEach : config, latched on start
//   pnRestart    : LFSR reload pulse (PRELOAD)
//   pnGate       : high in BURST
//   bitValid     : pnClkEn qualified by BURST (combinational)
//   busy, done   : not-IDLE flag, completion pulse
//   burstIdx     : zero-based current burst index
module pngen_burst_ctrl
    import pngen_burst_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pnClkEn,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] burstLen,
    input  logic [LEN_W-1:0] gapLen,
    input  logic [CNT_W-1:0] burstCount,
    input  logic             restartEach,
    output logic             pnRestart,
    output logic             pnGate,
    output logic             bitValid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] burstIdx
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, gap_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rst_each_q;
    logic             pn_restart_q, pn_gate_q, busy_q, done_q;

    logic             latch_d;
    logic             bit_ld, bit_inc, idx_ld, idx_inc;
    logic [LEN_W-1:0] bit_term_val;
    logic [LEN_W-1:0] bit_cnt;
    logic             bit_term;
    logic [CNT_W-1:0] idx;
    logic             idx_term;
    logic             last_burst;
    logic             unused_bit_cnt;

    // Shared bit/gap counter terminal: a zero burst length behaves as one bit.
    always_comb begin
        bit_term_val = '0;
        if (state_q == ST_GAP) begin
            bit_term_val = gap_q - LEN_W'(1);
        end else if (len_q != '0) begin
            bit_term_val = len_q - LEN_W'(1);
        end
    end

    pngen_strobe_cnt #(.W(LEN_W)) u_bit_cnt (
        .clk      (clk),
        .rst_n    (reset),
        .ld_i     (bit_ld),
        .ld_val_i ('0),
        .inc_i    (bit_inc),
        .term_i   (bit_term_val),
        .cnt_o    (bit_cnt),
        .term_c   (bit_term)
    );

    pngen_strobe_cnt #(.W(CNT_W)) u_idx_cnt (
        .clk      (clk),
        .rst_n    (reset),
        .ld_i     (idx_ld),
        .ld_val_i ('0),
        .inc_i    (idx_inc),
        .term_i   (cnt_q - CNT_W'(1)),
        .cnt_o    (idx),
        .term_c   (idx_term)
    );

    assign unused_bit_cnt = ^bit_cnt;

    // A zero burst count means continuous: no burst is ever the last one.
    assign last_burst = (cnt_q != '0) && idx_term;

    // Next-state and counter control.
    always_comb begin
        state_d = state_q;
        latch_d = 1'b0;
        bit_ld  = 1'b0;
        bit_inc = 1'b0;
        idx_ld  = 1'b0;
        idx_inc = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            bit_ld  = 1'b1;
            idx_ld  = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        latch_d = 1'b1;
                        bit_ld  = 1'b1;
                        idx_ld  = 1'b1;
                        state_d = ST_PRELOAD;
                    end
                end
                ST_PRELOAD: begin
                    state_d = ST_BURST;
                end
                ST_BURST: begin
                    if (pnClkEn) begin
                        if (bit_term) begin
                            bit_ld = 1'b1;
                            if (last_burst) begin
                                state_d = ST_DONE;
                            end else if (gap_q != '0) begin
                                state_d = ST_GAP;
                            end else begin
                                idx_inc = 1'b1;
                                state_d = rst_each_q ? ST_PRELOAD : ST_BURST;
                            end
                        end else begin
                            bit_inc = 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (pnClkEn) begin
                        if (bit_term) begin
                            bit_ld  = 1'b1;
                            idx_inc = 1'b1;
                            state_d = rst_each_q ? ST_PRELOAD : ST_BURST;
                        end else begin
                            bit_inc = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    idx_ld  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, latched config and registered outputs (decoded from next state).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            gap_q        <= '0;
            cnt_q        <= '0;
            rst_each_q   <= 1'b0;
            pn_restart_q <= 1'b0;
            pn_gate_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_d) begin
                len_q      <= burstLen;
                gap_q      <= gapLen;
                cnt_q      <= burstCount;
                rst_each_q <= restartEach;
            end
            pn_restart_q <= (state_d == ST_PRELOAD);
            pn_gate_q    <= (state_d == ST_BURST);
            busy_q       <= (state_d != ST_IDLE);
            done_q       <= (state_d == ST_DONE);
        end
    end

    assign pnRestart = pn_restart_q;
    assign pnGate    = pn_gate_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign burstIdx  = idx;
    assign bitValid  = pnClkEn && (state_q == ST_BURST);

endmodule

// File: tb/tb_pngen_burst_ctrl.sv
// Self-checking bench for pngen_burst_ctrl: table-driven sequences plus
// hand-written reset, latency, abort and continuous-mode corner cases.
module tb_pngen_burst_ctrl;

    logic        clk;
    logic        reset;
    logic        pnClkEn;
    logic        start;
    logic        abort;
    logic [15:0] burstLen;
    logic [15:0] gapLen;
    logic [7:0]  burstCount;
    logic        restartEach;
    logic        pnRestart;
    logic        pnGate;
    logic        bitValid;
    logic        busy;
    logic        done;
    logic [7:0]  burstIdx;

    int tests_run;
    int tests_failed;

    pngen_burst_ctrl #(.LEN_W(16), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .pnClkEn     (pnClkEn),
        .start       (start),
        .abort       (abort),
        .burstLen    (burstLen),
        .gapLen      (gapLen),
        .burstCount  (burstCount),
        .restartEach (restartEach),
        .pnRestart   (pnRestart),
        .pnGate      (pnGate),
        .bitValid    (bitValid),
        .busy        (busy),
        .done        (done),
        .burstIdx    (burstIdx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] blen;
        logic [15:0] glen;
        logic [15:0] new_len;
        logic [7:0]  bcnt;
        logic        rst_each;
        int          period;
        int          exp_bv;
        int          exp_rst;
        int          exp_done;
        int          exp_maxidx;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic outs_zero(input string name);
        check(name, int'({pnRestart, pnGate, bitValid, busy, done, burstIdx}), 0);
    endtask

    task automatic pulse_start(input vec_t v);
        @(posedge clk); #1;
        burstLen    = v.blen;
        gapLen      = v.glen;
        burstCount  = v.bcnt;
        restartEach = v.rst_each;
        pnClkEn     = 1'b0;
        start       = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
    endtask

    // Runs one table sequence to completion and scores pulse counts.
    task automatic run_vec(input int n, input vec_t v);
        int bv, rs, dn, maxidx, viol;
        bit fin, prev_done, prev_rst, busy_after_done;
        bv = 0; rs = 0; dn = 0; maxidx = 0; viol = 0;
        fin = 0; prev_done = 0; prev_rst = 0; busy_after_done = 0;
        pulse_start(v);
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            pnClkEn = ((cyc % v.period) == 0);
            if (cyc == 5 && v.new_len != 16'd0) burstLen = v.new_len;
            @(negedge clk);
            if (!busy) begin
                fin = 1;
                busy_after_done = prev_done;
            end else begin
                if (bitValid) bv++;
                if (pnRestart) rs++;
                if (done) dn++;
                if (int'(burstIdx) > maxidx) maxidx = int'(burstIdx);
                if (prev_rst && !pnGate) viol++;
                prev_rst  = pnRestart;
                prev_done = done;
                @(posedge clk); #1;
            end
        end
        pnClkEn = 1'b0;
        check($sformatf("v%0d_finished", n), int'(fin), 1);
        check($sformatf("v%0d_bitvalid", n), bv, v.exp_bv);
        check($sformatf("v%0d_pnrestart", n), rs, v.exp_rst);
        check($sformatf("v%0d_done", n), dn, v.exp_done);
        check($sformatf("v%0d_maxidx", n), maxidx, v.exp_maxidx);
        check($sformatf("v%0d_restart_then_burst", n), viol, 0);
        check($sformatf("v%0d_busy_falls_after_done", n), int'(busy_after_done), 1);
    endtask

    initial begin
        vec_t v;
        int   bv, rs, dn;
        bit   wrapped, fin;
        logic [7:0] prev_idx;

        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        pnClkEn      = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        burstLen     = 16'd0;
        gapLen       = 16'd0;
        burstCount   = 8'd0;
        restartEach  = 1'b0;

        //           blen   glen   newlen bcnt  re  per bv  rs dn maxidx
        vecs[0] = '{16'd4, 16'd2, 16'd0, 8'd3, 1'b0, 3, 12, 1, 1, 2};
        vecs[1] = '{16'd4, 16'd2, 16'd0, 8'd3, 1'b1, 3, 12, 3, 1, 2};
        vecs[2] = '{16'd0, 16'd0, 16'd0, 8'd2, 1'b0, 1,  2, 1, 1, 1};
        vecs[3] = '{16'd3, 16'd0, 16'd0, 8'd2, 1'b1, 1,  6, 2, 1, 1};
        vecs[4] = '{16'd1, 16'd1, 16'd0, 8'd4, 1'b0, 2,  4, 1, 1, 3};
        vecs[5] = '{16'd5, 16'd0, 16'd0, 8'd1, 1'b0, 1,  5, 1, 1, 0};
        vecs[6] = '{16'd4, 16'd0, 16'd9, 8'd3, 1'b0, 1, 12, 1, 1, 2};
        vecs[7] = '{16'd9, 16'd3, 16'd0, 8'd2, 1'b1, 2, 18, 2, 1, 1};

        // Reset state, with a strobe present.
        repeat (3) @(posedge clk);
        @(negedge clk);
        outs_zero("reset_outputs");
        reset   = 1'b1;
        pnClkEn = 1'b0;

        // Latency: start -> PRELOAD -> BURST; strobe in PRELOAD ignored.
        v = '{16'd2, 16'd0, 16'd0, 8'd1, 1'b0, 1, 0, 0, 0, 0};
        @(posedge clk); #1;
        burstLen = v.blen; gapLen = v.glen; burstCount = v.bcnt; restartEach = v.rst_each;
        start = 1'b1; pnClkEn = 1'b1;
        @(negedge clk);
        check("lat_idle", int'(busy), 0);
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        check("lat_preload", int'({busy, pnRestart, pnGate, bitValid}), 4'b1100);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_burst_bit0", int'({busy, pnRestart, pnGate, bitValid}), 4'b1011);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_burst_bit1", int'({busy, pnRestart, pnGate, bitValid}), 4'b1011);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_done", int'({busy, done, pnGate, bitValid}), 4'b1100);
        @(posedge clk); #1;
        @(negedge clk);
        outs_zero("lat_back_idle");
        pnClkEn = 1'b0;

        // Start and abort together: abort wins.
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("start_abort_same", int'({busy, pnRestart}), 0);

        // Table-driven sequences.
        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Continuous mode: 300 strobes, wrap 255->0, ignored start, abort.
        v = '{16'd1, 16'd0, 16'd0, 8'd0, 1'b0, 1, 0, 0, 0, 0};
        pulse_start(v);
        bv = 0; rs = 0; dn = 0; wrapped = 0; fin = 0; prev_idx = 8'd0;
        pnClkEn = 1'b1;
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            @(negedge clk);
            if (bitValid) bv++;
            if (pnRestart) rs++;
            if (done) dn++;
            if (prev_idx == 8'd255 && burstIdx == 8'd0) wrapped = 1;
            prev_idx = burstIdx;
            if (bv == 300) fin = 1;
            @(posedge clk); #1;
            start = (bv == 100) && bitValid;
            if (fin) pnClkEn = 1'b0;
        end
        start = 1'b0;
        @(negedge clk);
        check("cont_finished", int'(fin), 1);
        check("cont_idx_after_300", int'(burstIdx), 44);
        check("cont_wrapped", int'(wrapped), 1);
        check("cont_single_restart", rs, 1);
        check("cont_no_done", dn, 0);
        check("cont_still_busy", int'({busy, pnGate}), 2'b11);
        @(posedge clk); #1;
        abort = 1'b1; pnClkEn = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        outs_zero("abort_outputs");
        pnClkEn = 1'b0;

        // Asynchronous reset while in GAP.
        v = '{16'd2, 16'd5, 16'd0, 8'd3, 1'b0, 1, 0, 0, 0, 0};
        pulse_start(v);
        pnClkEn = 1'b1;
        fin = 0;
        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            @(negedge clk);
            if (busy && !pnGate && !pnRestart && !done) fin = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("reached_gap", int'(fin), 1);
        #2 reset = 1'b0;
        #1;
        outs_zero("async_reset_mid_gap");
        @(negedge clk);
        reset = 1'b1;
        dn = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (busy || done) dn++;
        end
        check("reset_no_resume", dn, 0);
        pnClkEn = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
